// File: rtl/cont_updown_modn_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cont_updown_modn_if : control/status bundle for the up/down modulo-N counter
// Rev 1.0
// ---------------------------------------------------------------------------
interface cont_updown_modn_if #(
  parameter int WIDTH = 2
);
  logic             En;
  logic             Y;
  logic             PosMin;
  logic             PosMax;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             AtMin;
  logic             AtMax;
  logic             Carry;
  logic             Borrow;
  logic             LoadErr;

  modport master (
    output En, Y, PosMin, PosMax, Load, D,
    input  Q, AtMin, AtMax, Carry, Borrow, LoadErr
  );

  modport slave (
    input  En, Y, PosMin, PosMax, Load, D,
    output Q, AtMin, AtMax, Carry, Borrow, LoadErr
  );
endinterface
`default_nettype wire

// File: rtl/cont_updown_modn.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cont_updown_modn : up/down modulo-N counter, wrap or saturate, with presets
// Rev 1.0
// ---------------------------------------------------------------------------
module cont_updown_modn #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4,
  parameter int MODE    = 0
) (
  input  wire logic         Clk,
  input  wire logic         Rst_n,
  cont_updown_modn_if.slave bus
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic             r_borrow;
  logic             r_loaderr;
  logic             w_load_oor;

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_cfg
    $error("cont_updown_modn: MODULUS must lie in 2..2**WIDTH");
  end

  // A full-range modulus can never see an out-of-range load value.
  if (MODULUS < (2 ** WIDTH)) begin : g_load_check
    assign w_load_oor = (bus.D > c_max);
  end else begin : g_load_nocheck
    assign w_load_oor = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_q       <= c_zero;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_loaderr <= 1'b0;
    end else begin
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_loaderr <= 1'b0;
      if (bus.PosMin) begin
        r_q <= c_zero;
      end else if (bus.PosMax) begin
        r_q <= c_max;
      end else if (bus.Load) begin
        if (w_load_oor) begin
          r_q       <= c_max;
          r_loaderr <= 1'b1;
        end else begin
          r_q <= bus.D;
        end
      end else if (bus.En) begin
        if (bus.Y) begin
          if (r_q == c_max) begin
            r_carry <= 1'b1;
            if (MODE == 0) r_q <= c_zero;
          end else begin
            r_q <= r_q + c_one;
          end
        end else begin
          if (r_q == c_zero) begin
            r_borrow <= 1'b1;
            if (MODE == 0) r_q <= c_max;
          end else begin
            r_q <= r_q - c_one;
          end
        end
      end
    end
  end

  assign bus.Q       = r_q;
  assign bus.AtMin   = (r_q == c_zero);
  assign bus.AtMax   = (r_q == c_max);
  assign bus.Carry   = r_carry;
  assign bus.Borrow  = r_borrow;
  assign bus.LoadErr = r_loaderr;

endmodule
`default_nettype wire

// File: doc/cont_updown_modn.md
Name: cont_updown_modn

Overview:
- Parametrised synchronous up/down modulo-N counter; successor to the 2-bit mod-4 preset counter used for valve/level position tracking in the irrigation controller.
- Adds generic width and modulus, count enable, parallel load, wrap or saturate mode, terminal-count flags and registered carry/borrow pulses for cascading stages.
- Drives the position decoder and the irrigation sequencing FSM.

Parameters:
- WIDTH, 2, counter register width in bits.
- MODULUS, 4, number of count states; valid range 2..2^WIDTH; the count runs 0..MODULUS-1.
- MODE, 0, end-of-range behaviour: 0 = wrap around, 1 = saturate at the ends.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst_n  in  1  synchronous reset, active-low.
- En  in  1  count enable.
- Y  in  1  count direction: 1 = up, 0 = down.
- PosMin  in  1  synchronous preset of Q to 0.
- PosMax  in  1  synchronous preset of Q to MODULUS-1.
- Load  in  1  synchronous parallel load of D.
- D  in  WIDTH  load value.
- Q  out  WIDTH  current count.
- AtMin  out  1  combinational; 1 when Q == 0.
- AtMax  out  1  combinational; 1 when Q == MODULUS-1.
- Carry  out  1  registered one-cycle pulse on an up-count attempted at MODULUS-1.
- Borrow  out  1  registered one-cycle pulse on a down-count attempted at 0.
- LoadErr  out  1  registered one-cycle pulse when a Load value is out of range.

Behaviour:
- One clock (Clk). Reset is synchronous and active-low (Rst_n). No asynchronous paths.
- Reset: while Rst_n=0 at a rising edge, Q=0, Carry=0, Borrow=0, LoadErr=0. As a result, AtMin=1 and AtMax=0. Reset overrides every other input, including mid-count and mid-load.
- Priority per edge, highest first:
  - Rst_n=0
  - PosMin
  - PosMax
  - Load
  - En count
  - hold
- PosMin and PosMax asserted together: PosMin wins, Q=0.
- Any preset or load cycle suppresses counting for that cycle, even if En=1.
- Load:
  - D <= MODULUS-1: Q=D.
  - D >= MODULUS: Q=MODULUS-1 (clamped) and LoadErr=1 for exactly the following cycle.
- Count, En=1, Y=1:
  - Q < MODULUS-1: Q=Q+1, Carry=0.
  - Q = MODULUS-1, MODE=0: Q=0 and Carry=1.
  - Q = MODULUS-1, MODE=1: Q holds and Carry=1.
- Count, En=1, Y=0:
  - Q > 0: Q=Q-1, Borrow=0.
  - Q = 0, MODE=0: Q=MODULUS-1 and Borrow=1.
  - Q = 0, MODE=1: Q holds and Borrow=1.
- Pulse timing:
  - Carry, Borrow and LoadErr are registered. They become valid in the same cycle as the resulting Q and are deasserted on every edge that does not regenerate them.
  - Continuous saturation, or repeated wraps on consecutive edges, give a pulse on each qualifying edge, so the output stays high.
- En=0 with no preset or load: Q holds, all pulses 0.
- Y changes take effect on the next edge. There is no direction-change latency or glitch.
- When MODULUS < 2^WIDTH, Q never takes a value >= MODULUS from any input sequence.
- Arithmetic is WIDTH bits, unsigned. The wrap is an explicit compare against MODULUS-1, never a reliance on natural overflow. This makes non-power-of-two moduli (e.g. 5, 10) correct.
- Elaboration: MODULUS > 2^WIDTH or MODULUS < 2 is a configuration error and is flagged by a generate-time check.
- Latency: 1 cycle from any input to Q and to the pulse outputs. AtMin/AtMax follow Q combinationally (0-cycle decode).

Test Plan:
- Reset: WIDTH=2, MODULUS=4, MODE=0. Hold Rst_n=0 for 2 edges with En=1, Y=1 -> Q=0, AtMin=1, Carry=Borrow=LoadErr=0. Release; 3 up edges -> Q=1,2,3 and AtMax=1 at Q=3.
- Wrap: MODE=0, Q=3, one more up edge -> Q=0 with Carry=1 for one cycle. Then Y=0 -> Q=3 with Borrow=1 for one cycle, then Q=2 with Borrow=0.
- Saturation: MODE=1, MODULUS=4. 6 down edges from Q=2 -> Q=1,0,0,0,0,0; Borrow=0,0,1,1,1,1. Then PosMax -> Q=3, Borrow=0.
- Non-power-of-two: WIDTH=4, MODULUS=10, MODE=0. 12 up edges from 0 -> Q=1..9,0,1,2 with Carry only on the edge producing Q=0. Q never reaches 10-15.
- Load: WIDTH=4, MODULUS=10. Load D=7 with En=1 -> Q=7, LoadErr=0. Load D=12 -> Q=9, LoadErr=1 for one cycle. Simultaneous PosMin=PosMax=Load=1, D=5 -> Q=0.
- Reset mid-operation: MODE=0, counting up at Q=3 with PosMax=1. Drop Rst_n for one edge -> Q=0, Carry=0. Next edge with Rst_n=1, En=1, Y=1, presets 0 -> Q=1.
